// File: rtl/barrel_shifter_right_pipe.sv
// Four-stage pipelined right barrel shifter (LSR / ASR / ROR) with a valid/ready
// handshake on both ends and a single global stall.
module barrel_shifter_right_pipe #(
   parameter int unsigned WIDTH   = 16,
   parameter int unsigned SHAMT_W = 4
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [WIDTH-1:0]   bitsIn,
   input  logic [SHAMT_W-1:0] shamt,
   input  logic [1:0]         mode,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [WIDTH-1:0]   bitsOut
);

   // Rotate refills from the word itself; LSR/ASR/reserved refill from the fill bit.
   function automatic logic [WIDTH-1:0] shr_step(input logic [WIDTH-1:0] d,
                                                 input int unsigned      n,
                                                 input logic [1:0]       m,
                                                 input logic             f);
      logic [WIDTH-1:0] src;
      src = (m == 2'b10) ? d : {WIDTH{f}};
      return (d >> n) | (src << (WIDTH - n));
   endfunction

   logic             advance;

   logic [WIDTH-1:0] s1_data_q, s1_data_d;
   logic [2:0]       s1_shamt_q, s1_shamt_d;
   logic [1:0]       s1_mode_q, s1_mode_d;
   logic             s1_fill_q, s1_fill_d;
   logic             s1_valid_q, s1_valid_d;

   logic [WIDTH-1:0] s2_data_q, s2_data_d;
   logic [1:0]       s2_shamt_q, s2_shamt_d;
   logic [1:0]       s2_mode_q, s2_mode_d;
   logic             s2_fill_q, s2_fill_d;
   logic             s2_valid_q, s2_valid_d;

   logic [WIDTH-1:0] s3_data_q, s3_data_d;
   logic             s3_shamt_q, s3_shamt_d;
   logic [1:0]       s3_mode_q, s3_mode_d;
   logic             s3_fill_q, s3_fill_d;
   logic             s3_valid_q, s3_valid_d;

   logic [WIDTH-1:0] s4_data_q, s4_data_d;
   logic             s4_valid_q, s4_valid_d;

   // Reset forces the pipe open so in_ready stays high while it is asserted.
   assign advance   = reset | ~s4_valid_q | out_ready;
   assign in_ready  = advance;
   assign out_valid = s4_valid_q;
   assign bitsOut   = s4_data_q;

   always_comb begin
      s1_data_d  = s1_data_q;
      s1_shamt_d = s1_shamt_q;
      s1_mode_d  = s1_mode_q;
      s1_fill_d  = s1_fill_q;
      s1_valid_d = s1_valid_q;
      s2_data_d  = s2_data_q;
      s2_shamt_d = s2_shamt_q;
      s2_mode_d  = s2_mode_q;
      s2_fill_d  = s2_fill_q;
      s2_valid_d = s2_valid_q;
      s3_data_d  = s3_data_q;
      s3_shamt_d = s3_shamt_q;
      s3_mode_d  = s3_mode_q;
      s3_fill_d  = s3_fill_q;
      s3_valid_d = s3_valid_q;
      s4_data_d  = s4_data_q;
      s4_valid_d = s4_valid_q;

      if (advance) begin
         s1_fill_d  = (mode == 2'b01) ? bitsIn[WIDTH-1] : 1'b0;
         s1_data_d  = shamt[0] ? shr_step(bitsIn, 1, mode, s1_fill_d) : bitsIn;
         s1_shamt_d = shamt[3:1];
         s1_mode_d  = mode;
         s1_valid_d = in_valid;

         s2_data_d  = s1_shamt_q[0] ? shr_step(s1_data_q, 2, s1_mode_q, s1_fill_q) : s1_data_q;
         s2_shamt_d = s1_shamt_q[2:1];
         s2_mode_d  = s1_mode_q;
         s2_fill_d  = s1_fill_q;
         s2_valid_d = s1_valid_q;

         s3_data_d  = s2_shamt_q[0] ? shr_step(s2_data_q, 4, s2_mode_q, s2_fill_q) : s2_data_q;
         s3_shamt_d = s2_shamt_q[1];
         s3_mode_d  = s2_mode_q;
         s3_fill_d  = s2_fill_q;
         s3_valid_d = s2_valid_q;

         s4_data_d  = s3_shamt_q ? shr_step(s3_data_q, 8, s3_mode_q, s3_fill_q) : s3_data_q;
         s4_valid_d = s3_valid_q;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         s1_data_q  <= '0;
         s1_shamt_q <= '0;
         s1_mode_q  <= '0;
         s1_fill_q  <= 1'b0;
         s1_valid_q <= 1'b0;
         s2_data_q  <= '0;
         s2_shamt_q <= '0;
         s2_mode_q  <= '0;
         s2_fill_q  <= 1'b0;
         s2_valid_q <= 1'b0;
         s3_data_q  <= '0;
         s3_shamt_q <= 1'b0;
         s3_mode_q  <= '0;
         s3_fill_q  <= 1'b0;
         s3_valid_q <= 1'b0;
         s4_data_q  <= '0;
         s4_valid_q <= 1'b0;
      end else begin
         s1_data_q  <= s1_data_d;
         s1_shamt_q <= s1_shamt_d;
         s1_mode_q  <= s1_mode_d;
         s1_fill_q  <= s1_fill_d;
         s1_valid_q <= s1_valid_d;
         s2_data_q  <= s2_data_d;
         s2_shamt_q <= s2_shamt_d;
         s2_mode_q  <= s2_mode_d;
         s2_fill_q  <= s2_fill_d;
         s2_valid_q <= s2_valid_d;
         s3_data_q  <= s3_data_d;
         s3_shamt_q <= s3_shamt_d;
         s3_mode_q  <= s3_mode_d;
         s3_fill_q  <= s3_fill_d;
         s3_valid_q <= s3_valid_d;
         s4_data_q  <= s4_data_d;
         s4_valid_q <= s4_valid_d;
      end
   end

endmodule

// File: tb/tb_barrel_shifter_right_pipe.sv
// Scoreboard bench for barrel_shifter_right_pipe: the driver queues expected results
// on acceptance, an independent monitor pops and compares on each output transfer.
module tb_barrel_shifter_right_pipe;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [15:0] bitsIn = '0;
   logic [3:0]  shamt = '0;
   logic [1:0]  mode = '0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [15:0] bitsOut;

   barrel_shifter_right_pipe #(.WIDTH(16), .SHAMT_W(4)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .bitsIn(bitsIn), .shamt(shamt), .mode(mode), .out_valid(out_valid),
      .out_ready(out_ready), .bitsOut(bitsOut)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] exp;
      int          cyc;
      bit          exact;
   } sb_entry_t;

   sb_entry_t sb_q[$];
   int        n_cmp = 0;
   int        n_err = 0;
   int        cyc = 0;
   bit        rand_done = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [15:0] model(input logic [15:0] x, input logic [3:0] s,
                                         input logic [1:0] m);
      logic signed [15:0] sx;
      logic [31:0]        dbl;
      case (m)
         2'b01: begin
            sx = x;
            return sx >>> s;
         end
         2'b10: begin
            dbl = {x, x} >> s;
            return dbl[15:0];
         end
         default: return x >> s;
      endcase
   endfunction

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic issue(input logic [15:0] d, input logic [3:0] s, input logic [1:0] m,
                        input logic [15:0] exp, input bit exact);
      sb_entry_t e;
      int        t;
      t = 0;
      @(negedge clk);
      bitsIn   = d;
      shamt    = s;
      mode     = m;
      in_valid = 1'b1;
      #3;
      while (!in_ready) begin
         if (t > 500) begin
            $display("FAIL issue_timeout: in_ready stuck at %b expected 1", in_ready);
            $fatal(1, "input handshake timed out");
         end
         t++;
         @(negedge clk);
         #3;
      end
      e.exp   = exp;
      e.cyc   = cyc;
      e.exact = exact;
      sb_q.push_back(e);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic drain(input int budget);
      int t;
      t = 0;
      while (sb_q.size() != 0 && t < budget) begin
         @(negedge clk);
         t++;
      end
      n_cmp++;
      if (sb_q.size() != 0) begin
         n_err++;
         $display("FAIL drain_timeout: %0d results outstanding, expected 0", sb_q.size());
         sb_q.delete();
      end
   endtask

   // Monitor: samples mid-cycle, well after the negedge on which inputs change.
   initial begin
      bit          prev_stall;
      logic [15:0] prev_data;
      sb_entry_t   e;
      prev_stall = 1'b0;
      prev_data  = '0;
      forever begin
         @(negedge clk);
         #3;
         if (reset) begin
            prev_stall = 1'b0;
         end else begin
            if (prev_stall) begin
               check("hold_valid", {15'b0, out_valid}, 16'h0001);
               check("hold_data", bitsOut, prev_data);
            end
            check("in_ready", {15'b0, in_ready}, {15'b0, ~(out_valid & ~out_ready)});
            if (out_valid && out_ready) begin
               if (sb_q.size() == 0) begin
                  n_cmp++;
                  n_err++;
                  $display("FAIL spurious_out: out_valid=1 data=%h expected no output", bitsOut);
               end else begin
                  e = sb_q.pop_front();
                  check("result", bitsOut, e.exp);
                  n_cmp++;
                  if ((e.exact && (cyc - e.cyc) != 4) || (cyc - e.cyc) < 4) begin
                     n_err++;
                     $display("FAIL latency: got %0d cycles expected %s4", cyc - e.cyc,
                              e.exact ? "" : ">=");
                  end
               end
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = bitsOut;
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [15:0] d;
      logic [3:0]  s;
      logic [1:0]  m;

      // Reset values
      @(negedge clk);
      #3;
      check("ready_in_reset", {15'b0, in_ready}, 16'h0001);
      @(negedge clk);
      reset = 1'b0;
      #3;
      check("reset_out_valid", {15'b0, out_valid}, 16'h0000);
      check("reset_bits_out", bitsOut, 16'h0000);

      // Directed vectors, out_ready held high
      issue(16'h8000, 4'd4, 2'b00, 16'h0800, 1'b1);
      drain(20);
      issue(16'h8000, 4'd4, 2'b01, 16'hF800, 1'b1);
      issue(16'h7FF0, 4'd4, 2'b01, 16'h07FF, 1'b1);
      issue(16'h0001, 4'd1, 2'b10, 16'h8000, 1'b1);
      issue(16'h1234, 4'd8, 2'b10, 16'h3412, 1'b1);
      issue(16'hABCD, 4'd0, 2'b00, 16'hABCD, 1'b1);
      issue(16'hABCD, 4'd0, 2'b01, 16'hABCD, 1'b1);
      issue(16'hABCD, 4'd0, 2'b10, 16'hABCD, 1'b1);
      issue(16'hABCD, 4'd0, 2'b11, 16'hABCD, 1'b1);
      issue(16'h8001, 4'd15, 2'b11, 16'h0001, 1'b1);
      issue(16'h8001, 4'd15, 2'b00, 16'h0001, 1'b1);
      issue(16'h8001, 4'd15, 2'b01, 16'hFFFF, 1'b1);
      issue(16'h8001, 4'd15, 2'b10, 16'h0003, 1'b1);
      issue(16'h4000, 4'd15, 2'b01, 16'h0000, 1'b1);
      issue(16'hC3A5, 4'd7, 2'b01, 16'hFF87, 1'b1);
      issue(16'hC3A5, 4'd7, 2'b11, 16'h0187, 1'b1);
      issue(16'hC3A5, 4'd12, 2'b10, 16'h3A5C, 1'b1);
      drain(20);

      // Backpressure: six back-to-back LSR ops with a 3-cycle stall mid-stream
      fork
         begin
            issue(16'hFFFF, 4'd0, 2'b00, 16'hFFFF, 1'b0);
            issue(16'hFFFF, 4'd1, 2'b00, 16'h7FFF, 1'b0);
            issue(16'hFFFF, 4'd2, 2'b00, 16'h3FFF, 1'b0);
            issue(16'hFFFF, 4'd3, 2'b00, 16'h1FFF, 1'b0);
            issue(16'hFFFF, 4'd4, 2'b00, 16'h0FFF, 1'b0);
            issue(16'hFFFF, 4'd5, 2'b00, 16'h07FF, 1'b0);
         end
         begin
            repeat (5) @(negedge clk);
            out_ready = 1'b0;
            repeat (3) @(negedge clk);
            out_ready = 1'b1;
         end
      join
      drain(30);

      // Reset mid-flight discards everything in the pipe
      issue(16'h00F0, 4'd1, 2'b00, 16'h0078, 1'b0);
      issue(16'h00F0, 4'd2, 2'b00, 16'h003C, 1'b0);
      issue(16'h00F0, 4'd3, 2'b00, 16'h001E, 1'b0);
      @(negedge clk);
      reset = 1'b1;
      sb_q.delete();
      #3;
      check("ready_mid_reset", {15'b0, in_ready}, 16'h0001);
      @(negedge clk);
      reset = 1'b0;
      #3;
      check("post_reset_data", bitsOut, 16'h0000);
      for (int i = 0; i < 5; i++) begin
         check("post_reset_quiet", {15'b0, out_valid}, 16'h0000);
         @(negedge clk);
         #3;
      end
      issue(16'h9000, 4'd2, 2'b01, 16'hE400, 1'b1);
      drain(20);

      // Random traffic against the reference model
      fork
         begin
            for (int i = 0; i < 1000; i++) begin
               while ($urandom_range(0, 3) == 0) @(negedge clk);
               d = 16'($urandom);
               s = 4'($urandom_range(0, 15));
               m = 2'($urandom_range(0, 3));
               issue(d, s, m, model(d, s, m), 1'b0);
            end
            rand_done = 1'b1;
         end
         begin
            while (!rand_done) begin
               @(negedge clk);
               out_ready = ($urandom_range(0, 3) != 0);
            end
            out_ready = 1'b1;
         end
      join
      drain(50);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/barrel_shifter_right_pipe.md
Name: barrel_shifter_right_pipe

Overview:
Pipelined 16-bit right barrel shifter. It is the right-direction counterpart to the ALU's left-shift mux chain and serves the ALU's LSR/ASR/ROR operations.
- Four registered stages shift right by 1, 2, 4 and 8 under control of the shift-amount bits.
- Valid/ready handshake on both ends lets it sit between the ALU operand latch and the writeback mux with backpressure.

Parameters:
WIDTH, 16, data width in bits; fixed at 16 for this revision.
SHAMT_W, 4, shift-amount width, equal to log2(WIDTH).

Ports:
clk  input  1  system clock; all state updates on the rising edge.
reset  input  1  synchronous, active-high reset.
in_valid  input  1  operand/command present.
in_ready  output  1  stage 1 can accept this cycle.
bitsIn  input  16  operand.
shamt  input  4  shift amount, 0..15.
mode  input  2  00 = logical right (LSR), 01 = arithmetic right (ASR), 10 = rotate right (ROR), 11 = reserved (behaves as LSR).
out_valid  output  1  result valid.
out_ready  input  1  consumer accepts the result.
bitsOut  output  16  shifted result.

Behaviour:
- Pipeline structure:
  - Stage k (k = 1..4) shifts by 2^(k-1) when shamt bit (k-1) is set; otherwise it passes data unchanged.
  - Each stage register holds: data[15:0], the remaining shamt bits, mode, fill bit, and a valid flag.
- Fill bit:
  - Captured at entry: bitsIn[15] when mode = 01, else 0.
  - LSR/reserved: vacated MSBs are 0.
  - ASR: vacated MSBs equal the captured fill bit.
  - ROR: bits shifted out of the LSB end re-enter at the MSB end.
- Stall rule (global): advance = !stage4_valid | out_ready.
  - When advance = 1, every stage loads from its predecessor. Stage 1 loads from the inputs, with valid = in_valid.
  - When advance = 0, all stage registers hold.
- in_ready = advance, combinational from stage4_valid and out_ready.
- Input acceptance: a transfer occurs when in_valid & in_ready.
- Output: out_valid = stage4_valid; bitsOut = stage4 data. Both are registered, so there is no combinational input-to-output path.
- Latency: exactly 4 cycles from an accepted input to out_valid, when out_ready has been held high.
- Throughput: 1 result per cycle with out_ready high.
- Bubbles: an invalid slot propagates as a bubble. Bubbles are not squeezed out during a stall, because the stall is global.
- Output hold: while out_valid = 1 and out_ready = 0, bitsOut and out_valid are held stable. No result may be dropped or duplicated.
- Boundary cases:
  - shamt = 0: passthrough for all modes.
  - shamt = 15, LSR: result is bitsIn[15] in bit 0, all other bits 0.
  - shamt = 15, ASR: all bits equal bitsIn[15].
  - shamt = 15, ROR: result is {bitsIn[14:0], bitsIn[15]}.
  - Reserved mode: result identical to LSR.
- Reset:
  - All stage valid flags, data, shamt, mode and fill registers clear to 0. out_valid = 0 and bitsOut = 16'h0000 in the cycle after reset is sampled high.
  - in_ready = 1 during and after reset.
  - Reset mid-operation discards all in-flight results. No stale out_valid may appear afterwards.
  - Reset has priority over advance/stall.
- Inputs are sampled only on acceptance; changing bitsIn, shamt or mode while not accepted has no effect.

Test Plan:
- Reset, then in_valid = 1, bitsIn = 16'h8000, shamt = 4, mode = 00, out_ready = 1 -> out_valid high exactly 4 cycles later, bitsOut = 16'h0800.
- Same operand with mode = 01 -> bitsOut = 16'hF800. Then bitsIn = 16'h7FF0, shamt = 4, mode = 01 -> bitsOut = 16'h07FF.
- Rotate cases:
  - bitsIn = 16'h0001, shamt = 1, mode = 10 -> 16'h8000.
  - bitsIn = 16'h1234, shamt = 8, mode = 10 -> 16'h3412.
  - bitsIn = 16'hABCD, shamt = 0, any mode -> 16'hABCD.
  - bitsIn = 16'h8001, shamt = 15, mode = 11 -> 16'h0001.
- Backpressure:
  - Stream 6 back-to-back ops (shamt = 0..5 on 16'hFFFF, LSR) with out_ready = 1; drop out_ready low for 3 cycles mid-stream.
  - Required: in_ready low during the stall, bitsOut held constant, and all 6 results (FFFF, 7FFF, 3FFF, 1FFF, 0FFF, 07FF) delivered in order with no loss or duplicates.
- Reset mid-flight: accept 3 ops, assert reset for 1 cycle at cycle 2 -> out_valid stays 0 for the following 5 cycles; the next accepted op completes normally after 4 cycles.
- Random compare: 1000 random bitsIn/shamt/mode values with random in_valid and out_ready -> every output matches a reference-model shift, in order, with latency ≥ 4.
